truth_table_checker: RTL and testbench
======================================

Name: truth_table_checker

Overview:
Self-checking response end for the small combinational gate puzzles, such as the bigger OR gate.
- Sweeps every input combination of an N_IN-input gate DUT and holds each vector for SETTLE cycles.
- Samples the DUT output and compares it against a selectable reference function.
- Reports mismatch count, first failing vector and a pass/done verdict.
- Replaces hand-written per-gate stimulus/eyeball checking in the gate benches and synthesises for on-board self-test.

Parameters:
N_IN, 3, number of DUT inputs; sweep length is 2^N_IN vectors (N_IN >= 1).
SETTLE, 2, cycles each vector is held before sampling (SETTLE >= 1).
ERR_W, 8, width of the mismatch counter.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  single-cycle run request; accepted only in IDLE or DONE.
op  input  2  reference function, latched on start accept: 00 OR, 01 AND, 10 XOR (odd parity), 11 NOR.
dut_out  input  1  DUT response to stim.
stim  output  N_IN  vector driven to DUT inputs; stim[0] maps to in0.
busy  output  1  high while sweeping.
done  output  1  high once the sweep completes; holds until the next accepted start or reset.
pass  output  1  done && err_count==0.
err_count  output  ERR_W  mismatches in the current/last sweep; saturates at all-ones.
first_fail  output  N_IN  stim value of the first mismatch.
first_fail_valid  output  1  high once first_fail has been captured.

Behaviour:
- Reset (async, any state, including mid-sweep): state=IDLE; stim, busy, done, pass, err_count, first_fail and first_fail_valid all 0; settle counter 0; latched op 00.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 at an edge:
  - Enter RUN; stim=0 and settle counter=0.
  - Clear err_count, first_fail and first_fail_valid; clear done.
  - Latch op; busy=1 from the next cycle.
- RUN:
  - Settle counter increments each edge.
  - On the edge where the counter == SETTLE-1, sample dut_out against expected(stim, op).
  - On mismatch: err_count+1, saturating at 2^ERR_W-1. If first_fail_valid==0, capture first_fail=stim and set first_fail_valid=1.
  - On the same edge, counter returns to 0. If stim != all-ones, stim increments; otherwise go to DONE with busy=0, done=1 and stim=0.
- Timing: each vector is held exactly SETTLE cycles. From the accept edge to done rising is 2^N_IN*SETTLE cycles (16 for defaults).
- start while RUN is ignored and does not restart the sweep.
- start in DONE restarts and clears the results on the same edge.
- op changes during RUN have no effect.
- stim == 0 whenever not in RUN.
- Expected functions:
  - OR: |stim.
  - AND: &stim.
  - XOR: ^stim.
  - NOR: ~|stim.
- All outputs are registered; no combinational path from dut_out to any output.

Test Plan:
1. Correct OR DUT, op=00, start pulse → stim steps 000..111, each held 2 cycles; done=1 after 16 cycles; err_count=0; pass=1; first_fail_valid=0.
2. DUT stuck-at-0, op=00 → err_count=7, first_fail=3'b001, first_fail_valid=1, pass=0.
3. DUT computes XOR, op=00 → mismatches at 011, 101 and 110; err_count=3; first_fail=3'b011.
4. Assert rst 5 cycles into a sweep → all outputs 0 immediately (async, before the next edge); start afterwards gives a full clean 16-cycle sweep.
5. start re-pulsed at cycle 4 of a run → ignored, done still at cycle 16. start pulsed in DONE → err_count/done cleared, new sweep runs with the newly latched op.
6. ERR_W=2, DUT stuck-at-0, op=00 → err_count saturates at 3 with no wrap; N_IN=1, SETTLE=1, op=11, correct NOR DUT → done after 2 cycles, pass=1.

Source files
------------

// File: rtl/truth_table_checker_if.sv
// Bus between the truth-table checker and whatever drives it / the gate under test.
// Grouping start/op with the gate's stim/dut_out keeps the bench wiring to one object.
interface truth_table_checker_if #(
  parameter int N_IN  = 3,
  parameter int ERR_W = 8
);
  // start is a single-cycle request with no ready: it is taken on any edge where the
  // checker sits in IDLE or DONE and dropped while busy; completion is signalled by done.
  logic             start;
  logic [1:0]       op;
  logic             dut_out;
  logic [N_IN-1:0]  stim;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [N_IN-1:0]  first_fail;
  logic             first_fail_valid;

  modport master (
    output start, op, dut_out,
    input  stim, busy, done, pass, err_count, first_fail, first_fail_valid
  );

  modport slave (
    input  start, op, dut_out,
    output stim, busy, done, pass, err_count, first_fail, first_fail_valid
  );
endinterface

// File: rtl/truth_table_checker.sv
// Exhaustive sweep of an N_IN-input gate: every vector held SETTLE cycles, the response
// compared against OR/AND/XOR/NOR, with mismatch count, first failing vector and verdict.
module truth_table_checker #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  truth_table_checker_if.slave bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  state_t           state_q, state_d;
  logic [N_IN-1:0]  stim_q, stim_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [N_IN-1:0]  ff_q, ff_d;
  logic             ffv_q, ffv_d;

  logic exp_bit;
  logic sample_now;
  logic mismatch;

  always_comb begin
    exp_bit = 1'b0;
    case (op_q)
      2'b00:   exp_bit = |stim_q;
      2'b01:   exp_bit = &stim_q;
      2'b10:   exp_bit = ^stim_q;
      default: exp_bit = ~(|stim_q);
    endcase
  end

  assign sample_now = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
  assign mismatch   = sample_now && (bus.dut_out != exp_bit);

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ff_d    = ff_q;
    ffv_d   = ffv_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          stim_d  = '0;
          cnt_d   = '0;
          op_d    = bus.op;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          ff_d    = '0;
          ffv_d   = 1'b0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + 1'b1;
          if (!ffv_q) begin
            ff_d  = stim_q;
            ffv_d = 1'b1;
          end
        end
        if (sample_now) begin
          cnt_d = '0;
          if (stim_q != '1) begin
            stim_d = stim_q + 1'b1;
          end else begin
            // Last vector: verdict uses the count including this final sample.
            state_d = ST_DONE;
            stim_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      stim_q  <= '0;
      cnt_q   <= '0;
      op_q    <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
    end
  end

  assign bus.stim             = stim_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_q;
  assign bus.first_fail       = ff_q;
  assign bus.first_fail_valid = ffv_q;
  assign dbg_state            = state_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: default build plus an ERR_W=2 build
// and an N_IN=1/SETTLE=1 build, each driving a small modelled gate.
module tb_truth_table_checker;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // gate model selector for instance a: 0 correct OR, 1 stuck-at-0, 2 XOR
  int mode_a;

  truth_table_checker_if #(.N_IN(3), .ERR_W(8)) if_a ();
  truth_table_checker_if #(.N_IN(3), .ERR_W(2)) if_b ();
  truth_table_checker_if #(.N_IN(1), .ERR_W(8)) if_c ();

  logic [1:0] dbg_a, dbg_b, dbg_c;

  assign if_a.dut_out = (mode_a == 0) ? (|if_a.stim) :
                        (mode_a == 1) ? 1'b0 : (^if_a.stim);
  assign if_b.dut_out = 1'b0;
  assign if_c.dut_out = ~(|if_c.stim);

  truth_table_checker #(.N_IN(3), .SETTLE(2), .ERR_W(8)) u_a (
    .clk(clk), .rst(rst), .bus(if_a), .dbg_state(dbg_a));
  truth_table_checker #(.N_IN(3), .SETTLE(2), .ERR_W(2)) u_b (
    .clk(clk), .rst(rst), .bus(if_b), .dbg_state(dbg_b));
  truth_table_checker #(.N_IN(1), .SETTLE(1), .ERR_W(8)) u_c (
    .clk(clk), .rst(rst), .bus(if_c), .dbg_state(dbg_c));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return if_a.done;
      1:       return if_b.done;
      default: return if_c.done;
    endcase
  endfunction

  // driver: pulse start on one instance, then count edges until done (bounded)
  task automatic start_and_wait(input int sel, input logic [1:0] op_v, output int cycles);
    @(negedge clk);
    case (sel)
      0: begin if_a.start = 1'b1; if_a.op = op_v; end
      1: begin if_b.start = 1'b1; if_b.op = op_v; end
      default: begin if_c.start = 1'b1; if_c.op = op_v; end
    endcase
    @(posedge clk); #1;
    if_a.start = 1'b0; if_b.start = 1'b0; if_c.start = 1'b0;
    cycles = 0;
    while (!done_of(sel) && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({if_a.stim, if_a.busy, if_a.done, if_a.pass, if_a.err_count, if_a.first_fail,
         if_a.first_fail_valid, dbg_a} !== '0) begin
      errors++;
      $display("FAIL reset_a: stim=%0d busy=%0b done=%0b pass=%0b err=%0d ff=%0d ffv=%0b st=%0d, want all 0",
               if_a.stim, if_a.busy, if_a.done, if_a.pass, if_a.err_count, if_a.first_fail,
               if_a.first_fail_valid, dbg_a);
    end
    checks++;
    if ({if_b.busy, if_b.done, if_b.err_count, if_c.busy, if_c.done, if_c.stim} !== '0) begin
      errors++;
      $display("FAIL reset_bc: b busy=%0b done=%0b err=%0d c busy=%0b done=%0b stim=%0d, want 0",
               if_b.busy, if_b.done, if_b.err_count, if_c.busy, if_c.done, if_c.stim);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_or_correct();
    mode_a = 0;
    @(negedge clk);
    if_a.start = 1'b1; if_a.op = 2'b00;
    @(posedge clk); #1;
    if_a.start = 1'b0;
    checks++;
    if (if_a.busy !== 1'b1 || if_a.stim !== 3'd0 || dbg_a !== 2'd1) begin
      errors++;
      $display("FAIL or_accept: busy=%0b stim=%0d st=%0d, want 1 0 1", if_a.busy, if_a.stim, dbg_a);
    end
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      checks++;
      if (c < 16) begin
        if (if_a.stim !== 3'(c / 2) || if_a.done !== 1'b0 || if_a.busy !== 1'b1) begin
          errors++;
          $display("FAIL or_step%0d: stim=%0d done=%0b busy=%0b, want stim=%0d done=0 busy=1",
                   c, if_a.stim, if_a.done, if_a.busy, c / 2);
        end
      end else begin
        if (if_a.done !== 1'b1 || if_a.busy !== 1'b0 || if_a.stim !== 3'd0) begin
          errors++;
          $display("FAIL or_done_at16: done=%0b busy=%0b stim=%0d, want 1 0 0",
                   if_a.done, if_a.busy, if_a.stim);
        end
      end
    end
    checks++;
    if (if_a.err_count !== 8'd0 || if_a.pass !== 1'b1 || if_a.first_fail_valid !== 1'b0 ||
        dbg_a !== 2'd2) begin
      errors++;
      $display("FAIL or_verdict: err=%0d pass=%0b ffv=%0b st=%0d, want 0 1 0 2",
               if_a.err_count, if_a.pass, if_a.first_fail_valid, dbg_a);
    end
  endtask

  task automatic test_stuck_at_0();
    int cyc;
    mode_a = 1;
    start_and_wait(0, 2'b00, cyc);
    checks++;
    if (cyc !== 16) begin
      errors++;
      $display("FAIL stuck0_latency: cycles=%0d, want 16", cyc);
    end
    checks++;
    if (if_a.err_count !== 8'd7 || if_a.first_fail !== 3'b001 || if_a.first_fail_valid !== 1'b1 ||
        if_a.pass !== 1'b0) begin
      errors++;
      $display("FAIL stuck0_result: err=%0d ff=%0d ffv=%0b pass=%0b, want 7 1 1 0",
               if_a.err_count, if_a.first_fail, if_a.first_fail_valid, if_a.pass);
    end
  endtask

  task automatic test_xor_vs_or();
    int cyc;
    mode_a = 2;
    start_and_wait(0, 2'b00, cyc);
    checks++;
    if (cyc !== 16 || if_a.err_count !== 8'd3 || if_a.first_fail !== 3'b011 ||
        if_a.first_fail_valid !== 1'b1 || if_a.pass !== 1'b0) begin
      errors++;
      $display("FAIL xor_result: cycles=%0d err=%0d ff=%0d ffv=%0b pass=%0b, want 16 3 3 1 0",
               cyc, if_a.err_count, if_a.first_fail, if_a.first_fail_valid, if_a.pass);
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    mode_a = 1;
    @(negedge clk);
    if_a.start = 1'b1; if_a.op = 2'b00;
    @(posedge clk); #1;
    if_a.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (if_a.err_count !== 8'd1 || if_a.stim !== 3'd2 || if_a.busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: err=%0d stim=%0d busy=%0b, want 1 2 1",
               if_a.err_count, if_a.stim, if_a.busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({if_a.stim, if_a.busy, if_a.done, if_a.pass, if_a.err_count, if_a.first_fail,
         if_a.first_fail_valid, dbg_a} !== '0) begin
      errors++;
      $display("FAIL midrst_async: stim=%0d busy=%0b done=%0b err=%0d ffv=%0b st=%0d, want all 0",
               if_a.stim, if_a.busy, if_a.done, if_a.err_count, if_a.first_fail_valid, dbg_a);
    end
    @(negedge clk);
    rst = 1'b0;
    mode_a = 0;
    start_and_wait(0, 2'b00, cyc);
    checks++;
    if (cyc !== 16 || if_a.pass !== 1'b1 || if_a.err_count !== 8'd0) begin
      errors++;
      $display("FAIL midrst_resweep: cycles=%0d pass=%0b err=%0d, want 16 1 0",
               cyc, if_a.pass, if_a.err_count);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    mode_a = 0;
    @(negedge clk);
    if_a.start = 1'b1; if_a.op = 2'b00;
    @(posedge clk); #1;
    if_a.start = 1'b0;
    cyc = 0;
    while (!if_a.done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 4) begin if_a.start = 1'b1; if_a.op = 2'b01; end
      if (cyc == 5) if_a.start = 1'b0;
    end
    checks++;
    if (cyc !== 16 || if_a.pass !== 1'b1 || if_a.err_count !== 8'd0) begin
      errors++;
      $display("FAIL b2b_ignore: cycles=%0d pass=%0b err=%0d, want 16 1 0",
               cyc, if_a.pass, if_a.err_count);
    end
    // restart from DONE with AND reference against the OR gate
    @(negedge clk);
    if_a.start = 1'b1; if_a.op = 2'b01;
    @(posedge clk); #1;
    if_a.start = 1'b0;
    checks++;
    if (if_a.done !== 1'b0 || if_a.err_count !== 8'd0 || if_a.first_fail_valid !== 1'b0 ||
        if_a.busy !== 1'b1 || if_a.pass !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart_clear: done=%0b err=%0d ffv=%0b busy=%0b pass=%0b, want 0 0 0 1 0",
               if_a.done, if_a.err_count, if_a.first_fail_valid, if_a.busy, if_a.pass);
    end
    cyc = 0;
    while (!if_a.done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 16 || if_a.err_count !== 8'd6 || if_a.first_fail !== 3'b001 || if_a.pass !== 1'b0) begin
      errors++;
      $display("FAIL b2b_and_result: cycles=%0d err=%0d ff=%0d pass=%0b, want 16 6 1 0",
               cyc, if_a.err_count, if_a.first_fail, if_a.pass);
    end
  endtask

  task automatic test_saturate();
    int cyc;
    start_and_wait(1, 2'b00, cyc);
    checks++;
    if (cyc !== 16 || if_b.err_count !== 2'd3 || if_b.first_fail !== 3'b001 || if_b.pass !== 1'b0) begin
      errors++;
      $display("FAIL sat_err: cycles=%0d err=%0d ff=%0d pass=%0b, want 16 3 1 0",
               cyc, if_b.err_count, if_b.first_fail, if_b.pass);
    end
  endtask

  task automatic test_nor_small();
    int cyc;
    start_and_wait(2, 2'b11, cyc);
    checks++;
    if (cyc !== 2 || if_c.pass !== 1'b1 || if_c.err_count !== 8'd0 || if_c.stim !== 1'b0 ||
        if_c.busy !== 1'b0) begin
      errors++;
      $display("FAIL nor_small: cycles=%0d pass=%0b err=%0d stim=%0d busy=%0b, want 2 1 0 0 0",
               cyc, if_c.pass, if_c.err_count, if_c.stim, if_c.busy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mode_a = 0;
    rst = 1'b1;
    if_a.start = 1'b0; if_a.op = 2'b00;
    if_b.start = 1'b0; if_b.op = 2'b00;
    if_c.start = 1'b0; if_c.op = 2'b00;
    test_reset();
    test_or_correct();
    test_stuck_at_0();
    test_xor_vs_or();
    test_mid_reset();
    test_back_to_back();
    test_saturate();
    test_nor_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
